// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants and clear-FSM encoding
// for the VGA plot sink and its framebuffer RAM.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_TOTAL  = 10'd800;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  localparam int FB_DEPTH = 19200;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vga_fb_ram.sv
// vga_fb_ram: simple dual-port framebuffer, write port A,
// registered read port B returning old data on a collision.
module vga_fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [DW-1:0] wdata_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem [DEPTH];

  // Write A and read B in one block so B sees pre-write contents.
  always_ff @(posedge clk) begin
    if (we_a_i) mem[addr_a_i] <= wdata_a_i;
    rdata_b_o <= mem[addr_b_i];
  end

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: pixel-plot sink with clear FSM, 160x120x3
// framebuffer and 640x480@60 scan-out with 4x4 replication.
module vga_plot_sink
  import vga_pkg::*;
#(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       vga_resetn,
  output logic       busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int DEPTH = FB_W * FB_H;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] W_AW  = AW'(FB_W);
  localparam logic [7:0]    X_LIM = 8'(FB_W);
  localparam logic [6:0]    Y_LIM = 7'(FB_H);

  localparam logic [9:0] HS_BEG = H_ACTIVE + H_FP;
  localparam logic [9:0] HS_END = HS_BEG + H_SYNC;
  localparam logic [9:0] VS_BEG = V_ACTIVE + V_FP;
  localparam logic [9:0] VS_END = VS_BEG + V_SYNC;

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          start_q;

  logic          we;
  logic [AW-1:0] waddr;
  logic [2:0]    wdata;
  logic [AW-1:0] plot_addr;
  logic          plot_ok;
  logic          clr_req;

  logic          pix_en_q;
  logic [9:0]    hcnt_q, hcnt_d;
  logic [9:0]    vcnt_q, vcnt_d;

  logic          active, hs_raw, vs_raw;
  logic [AW-1:0] raddr;
  logic [2:0]    rdata;

  logic          act1_q, hs1_q, vs1_q;
  logic [2:0]    rgb_q;
  logic          blank_q, hs_q, vs_q;

  assign plot_addr = AW'(y) * W_AW + AW'(x);
  assign plot_ok   = plot && (x < X_LIM) && (y < Y_LIM);
  // start_q turns reset release into a one-shot clear request.
  assign clr_req   = start_q || !vga_resetn;
  assign busy      = (state_q == S_CLEAR);

  // Clear FSM state, clear pointer and post-reset start flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      start_q    <= 1'b0;
    end
  end

  // Next state and write-port mux: clear always beats plot.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    waddr      = plot_addr;
    wdata      = colour;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (plot_ok) begin
          we = 1'b1;
        end
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = '0;
        if (!vga_resetn) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    endcase
  end

  // Horizontal/vertical counter advance on each pixel tick.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en_q) begin
      if (hcnt_q == H_TOTAL - 10'd1) begin
        hcnt_d = '0;
        if (vcnt_q == V_TOTAL - 10'd1) vcnt_d = '0;
        else vcnt_d = vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Pixel-tick divider and scan counters; free-running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en_q <= 1'b0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
    end else begin
      pix_en_q <= ~pix_en_q;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
    end
  end

  assign active = (hcnt_q < H_ACTIVE) && (vcnt_q < V_ACTIVE);
  assign hs_raw = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
  assign vs_raw = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  // Outside the active area the address is parked at 0.
  assign raddr  = active
                ? AW'(vcnt_q >> SCALE_LOG2) * W_AW
                  + AW'(hcnt_q >> SCALE_LOG2)
                : '0;

  vga_fb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (3)
  ) u_ram (
    .clk       (clk),
    .we_a_i    (we),
    .addr_a_i  (waddr),
    .wdata_a_i (wdata),
    .addr_b_i  (raddr),
    .rdata_b_o (rdata)
  );

  // Two-stage output pipe: syncs/blank delayed to match the RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      act1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      rgb_q   <= '0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      act1_q  <= active;
      hs1_q   <= hs_raw;
      vs1_q   <= vs_raw;
      rgb_q   <= act1_q ? rdata : 3'b000;
      blank_q <= act1_q;
      hs_q    <= hs1_q;
      vs_q    <= vs1_q;
    end
  end

  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  // DAC clock rises mid-pixel.
  assign vga_clk     = ~pix_en_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: randomized plots checked against a
// framebuffer model and screen-timing rules.
`timescale 1ns/1ps
module tb_vga_plot_sink;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       vga_resetn = 1'b1;
  logic       busy;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;
  logic       vga_sync_n, vga_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  logic [2:0] fb [120][160];

  vga_plot_sink dut (
    .clk         (clk),
    .resetn      (resetn),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .vga_resetn  (vga_resetn),
    .busy        (busy),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .vga_sync_n  (vga_sync_n),
    .vga_clk     (vga_clk)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;

  // Pins sampled after edge m show pixel tick (m-2)/2.
  function automatic int tick(int m);
    return (m - 2) / 2;
  endfunction

  function automatic logic [23:0] exp_rgb(int m);
    int t, h, v;
    logic [2:0] c;
    t = tick(m);
    h = t % 800;
    v = (t / 800) % 525;
    c = 3'b000;
    if (h < 640 && v < 480) c = fb[v / 4][h / 4];
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 160; c++)
        fb[r][c] = 3'b000;
  endtask

  task automatic do_plot(int px, int py, int pc);
    x = 8'(px);
    y = 7'(py);
    colour = 3'(pc);
    plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
    if (px < 160 && py < 120) fb[py][px] = 3'(pc);
  endtask

  task automatic wait_tick(int t);
    while (tick(cyc) < t) @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b expected 0", busy);
    end
    n_tests++;
    if ({vga_hs, vga_vs, vga_blank_n} !== 3'b110) begin
      n_fail++;
      $display("FAIL rst_sync: got %b expected 110",
               {vga_hs, vga_vs, vga_blank_n});
    end
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL rst_rgb: got %h expected 0",
               {vga_r, vga_g, vga_b});
    end
    n_tests++;
    if ({vga_sync_n, vga_clk} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_clk: got %b expected 01",
               {vga_sync_n, vga_clk});
    end
    resetn = 1'b1;
    model_clear();
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_rise: got %b expected 1", busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 25000) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != 19200) begin
      n_fail++;
      $display("FAIL rst_clear_len: got %0d expected 19200", cnt);
    end
  endtask

  task automatic test_single_plot();
    int lt;
    do_plot(5, 3, 3'b101);
    lt = 13 * 800;
    wait_tick(lt + 19);
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      n_fail++;
      $display("FAIL plot_left: got %h expected 000000",
               {vga_r, vga_g, vga_b});
    end
    wait_tick(lt + 20);
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'hFF00FF) begin
      n_fail++;
      $display("FAIL plot_first: got %h expected ff00ff",
               {vga_r, vga_g, vga_b});
    end
    wait_tick(lt + 23);
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'hFF00FF) begin
      n_fail++;
      $display("FAIL plot_last: got %h expected ff00ff",
               {vga_r, vga_g, vga_b});
    end
    wait_tick(lt + 24);
    n_tests++;
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      n_fail++;
      $display("FAIL plot_right: got %h expected 000000",
               {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_random_plots();
    logic [23:0] e;
    repeat (24)
      do_plot($urandom_range(0, 159), 4, $urandom_range(1, 7));
    repeat (16)
      do_plot($urandom_range(0, 159), 11, $urandom_range(1, 7));
    do_plot(160, 0, 7);
    do_plot(0, 120, 7);
    do_plot(160, 3, 7);
    do_plot(200, 3, 6);
    do_plot(255, 3, 5);
    wait_tick(16 * 800);
    while (tick(cyc) < 20 * 800) begin
      e = exp_rgb(cyc);
      n_tests++;
      if ({vga_r, vga_g, vga_b} !== e) begin
        n_fail++;
        $display("FAIL rgb_rand t=%0d: got %h expected %h",
                 tick(cyc), {vga_r, vga_g, vga_b}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sync_timing();
    int h, v, lo, bl, first;
    logic ehs, evs;
    for (int ln = 20; ln < 22; ln++) begin
      lo = 0;
      bl = 0;
      first = -1;
      wait_tick(ln * 800);
      while (tick(cyc) < (ln + 1) * 800) begin
        h = tick(cyc) % 800;
        v = (tick(cyc) / 800) % 525;
        ehs = !(h >= 656 && h < 752);
        evs = !(v >= 490 && v < 492);
        n_tests++;
        if ({vga_hs, vga_vs, vga_blank_n} !==
            {ehs, evs, (h < 640 && v < 480)}) begin
          n_fail++;
          $display("FAIL sync h=%0d v=%0d: got %b expected %b",
                   h, v, {vga_hs, vga_vs, vga_blank_n},
                   {ehs, evs, (h < 640 && v < 480)});
        end
        if (!vga_hs) begin
          lo++;
          if (first < 0) first = h;
        end
        if (vga_blank_n) bl++;
        @(negedge clk);
      end
      n_tests++;
      if (lo / 2 != 96 || first != 656) begin
        n_fail++;
        $display("FAIL hs_line %0d: got %0d ticks at %0d expected 96 at 656",
                 ln, lo / 2, first);
      end
      n_tests++;
      if (bl / 2 != 640) begin
        n_fail++;
        $display("FAIL blank_line %0d: got %0d expected 640",
                 ln, bl / 2);
      end
    end
  endtask

  task automatic test_clear_vs_plot();
    int cnt;
    x = 8'd7;
    y = 7'd11;
    colour = 3'd7;
    plot = 1'b1;
    vga_resetn = 1'b0;
    @(negedge clk);
    plot = 1'b0;
    vga_resetn = 1'b1;
    model_clear();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_enter: got %b expected 1", busy);
    end
    repeat (9999) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_mid: got %b expected 1", busy);
    end
    vga_resetn = 1'b0;
    plot = 1'b1;
    @(negedge clk);
    vga_resetn = 1'b1;
    plot = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 25000) begin
      cnt++;
      @(negedge clk);
    end
    n_tests++;
    if (cnt != 19200) begin
      n_fail++;
      $display("FAIL clr_restart_len: got %0d expected 19200", cnt);
    end
  endtask

  task automatic test_after_clear();
    logic [23:0] e;
    wait_tick(44 * 800);
    while (tick(cyc) < 48 * 800) begin
      e = exp_rgb(cyc);
      n_tests++;
      if ({vga_r, vga_g, vga_b} !== e) begin
        n_fail++;
        $display("FAIL rgb_cleared t=%0d: got %h expected %h",
                 tick(cyc), {vga_r, vga_g, vga_b}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    wait_tick(48 * 800 + 300);
    n_tests++;
    if (vga_blank_n !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_blank: got %b expected 1",
               vga_blank_n);
    end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({busy, vga_hs, vga_vs, vga_blank_n} !== 4'b0110) begin
      n_fail++;
      $display("FAIL async_ctl: got %b expected 0110",
               {busy, vga_hs, vga_vs, vga_blank_n});
    end
    n_tests++;
    if ({vga_r, vga_g, vga_b, vga_clk} !== 25'h1) begin
      n_fail++;
      $display("FAIL async_rgb: got %h expected 1",
               {vga_r, vga_g, vga_b, vga_clk});
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_random_plots();
    test_sync_timing();
    test_clear_vs_plot();
    test_after_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
